sdc_controller: RTL

SDC_CONTROLLER -- requirements
Module: sdc_controller

---
 rtl/sdc_pkg.sv | 15 +
 rtl/sdc_debounce.sv | 52 +++++
 rtl/sdc_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sdc_pkg.sv
// Shared types and default parameters for the shutdown-circuit controller.
package sdc_pkg;

   typedef enum logic [1:0] {
      StOpen   = 2'd0,
      StReady  = 2'd1,
      StClosed = 2'd2,
      StFault  = 2'd3
   } sdc_state_t;

   localparam int unsigned N_LOOPS_DEF    = 4;
   localparam int unsigned WD_TIMEOUT_DEF = 1000;
   localparam int unsigned DEBOUNCE_DEF   = 16;

endpackage

// File: rtl/sdc_debounce.sv
// Button debouncer: the level follows the raw input only after DEBOUNCE stable cycles;
// press_o pulses for one cycle on each accepted rising edge.
module sdc_debounce
   import sdc_pkg::*;
#(
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   input  logic restart_i,
   output logic press_o
);

   localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      if (restart_i || (raw_i == level_q)) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         // raw has differed from the level for DEBOUNCE consecutive cycles
         cnt_d   = '0;
         level_d = raw_i;
         press_d = raw_i;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/sdc_controller.sv
// Shutdown-circuit controller: supervises loop sense inputs and a watchdog heartbeat,
// and closes the SDC relay on a debounced activation press.
module sdc_controller
   import sdc_pkg::*;
#(
   parameter int unsigned N_LOOPS    = N_LOOPS_DEF,
   parameter int unsigned WD_TIMEOUT = WD_TIMEOUT_DEF,
   parameter int unsigned DEBOUNCE   = DEBOUNCE_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_LOOPS-1:0] shutdown_loop_i,
   input  logic               watchdog_i,
   input  logic               as_close_sdc_i,
   input  logic               as_driving_mode_i,
   input  logic               ts_btn_cockpit_i,
   input  logic               ts_btn_external_i,
   input  logic               fault_clear_i,
   output logic               sdc_to_relais_o,
   output logic               sdc_is_ready_o,
   output logic               fault_o,
   output logic [N_LOOPS:0]   fault_cause_o,
   output logic [1:0]         state_o
);

   localparam int unsigned WW = $clog2(WD_TIMEOUT + 1);
   localparam logic [WW-1:0] WD_MAX = WW'(WD_TIMEOUT);

   logic [N_LOOPS-1:0] loop_s1, loop_s2;
   logic               wd_s1, wd_s2, wd_prev;
   logic [1:0]         btn_s1, btn_s2;
   logic               mode_q;
   logic [WW-1:0]      wd_cnt_q, wd_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loop_s1 <= '0;
         loop_s2 <= '0;
         wd_s1   <= 1'b0;
         wd_s2   <= 1'b0;
         wd_prev <= 1'b0;
         btn_s1  <= '0;
         btn_s2  <= '0;
         mode_q  <= 1'b0;
      end else begin
         loop_s1 <= shutdown_loop_i;
         loop_s2 <= loop_s1;
         wd_s1   <= watchdog_i;
         wd_s2   <= wd_s1;
         wd_prev <= wd_s2;
         btn_s1  <= {ts_btn_external_i, ts_btn_cockpit_i};
         btn_s2  <= btn_s1;
         mode_q  <= as_driving_mode_i;
      end
   end

   logic loop_ok, wd_ok, sys_ok;

   assign loop_ok = &loop_s2;
   assign wd_ok   = (wd_cnt_q < WD_MAX);
   assign sys_ok  = loop_ok & wd_ok;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (wd_s2 != wd_prev) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q < WD_MAX) begin
         wd_cnt_d = wd_cnt_q + WW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd_cnt_q <= '0;
      else        wd_cnt_q <= wd_cnt_d;
   end

   logic btn_sel, press;

   assign btn_sel = as_driving_mode_i ? btn_s2[1] : btn_s2[0];

   sdc_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (btn_sel),
      .restart_i (as_driving_mode_i != mode_q),
      .press_o   (press)
   );

   sdc_state_t       state_q, state_d;
   logic [N_LOOPS:0] cause_q, cause_d;
   logic             relay_q, ready_q, fault_q;

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         StOpen: begin
            // loss of loop or heartbeat here is not a fault; just stay open
            if (sys_ok) state_d = StReady;
         end
         StReady: begin
            if (!sys_ok)                      state_d = StFault;
            else if (press && as_close_sdc_i) state_d = StClosed;
         end
         StClosed: begin
            if (!sys_ok)              state_d = StFault;
            else if (!as_close_sdc_i) state_d = StOpen;
         end
         StFault: begin
            if (fault_clear_i && sys_ok) state_d = StOpen;
         end
         default: state_d = StOpen;
      endcase

      if ((state_q != StFault) && (state_d == StFault)) begin
         cause_d = {~wd_ok, ~loop_s2};
      end else if ((state_q == StFault) && (state_d == StOpen)) begin
         cause_d = '0;
      end
   end

   // outputs are registered from the next state so they move with state_q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StOpen;
         cause_q <= '0;
         relay_q <= 1'b0;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         relay_q <= (state_d == StClosed);
         ready_q <= (state_d == StReady) || (state_d == StClosed);
         fault_q <= (state_d == StFault);
      end
   end

   assign sdc_to_relais_o = relay_q;
   assign sdc_is_ready_o  = ready_q;
   assign fault_o         = fault_q;
   assign fault_cause_o   = cause_q;
   assign state_o         = state_q;

endmodule
